// File: rtl/sram_phase_sequencer.sv
// -----------------------------------------------------------------------------
// sram_phase_sequencer
//
// Top-level phase controller and SRAM access multiplexer for the decoder
// datapath. The image arrives over UART into SRAM. Reception ends after
// TIMEOUT_CYCLES idle cycles on the UART write path. NUM_STAGES processing
// stages then run in order (stage 0 first) with start/finish handshakes.
// Finally SRAM is handed back to VGA.
//
// Optional build macro:
//   STAGE_WATCHDOG_EN - adds a per-stage cycle watchdog. The watchdog aborts to
//                       S_IDLE and sets a sticky error_o. When undefined,
//                       error_o is tied low and stages may run indefinitely.
//
// Ports:
//   CLOCK_50_I            in   50 MHz clock
//   resetn                in   asynchronous active-low reset
//   uart_rx_i             in   raw UART line (low = start bit), sampled in S_IDLE
//   uart_addr_i           in   UART SRAM address
//   uart_wdata_i          in   UART SRAM write data
//   uart_we_n_i           in   UART SRAM write enable (active low)
//   uart_rx_initialize_o  out  one-cycle pulse to the UART interface
//   uart_rx_enable_o      out  one-cycle pulse, one cycle after initialize
//   stage_addr_i          in   packed stage addresses, stage k at [k*ADDR_W +: ADDR_W]
//   stage_wdata_i         in   packed stage write data
//   stage_we_n_i          in   per-stage write enable (active low)
//   stage_finish_i        in   per-stage finish flag
//   stage_start_o         out  per-stage start level
//   vga_addr_i            in   VGA read address
//   vga_enable_o          out  VGA enable
//   sram_address_o        out  muxed SRAM address
//   sram_write_data_o     out  muxed SRAM write data
//   sram_we_n_o           out  muxed SRAM write enable (active low)
//   stage_idx_o           out  index of the active stage
//   busy_o                out  high whenever not in S_IDLE
//   error_o               out  sticky watchdog error
// -----------------------------------------------------------------------------
module sram_phase_sequencer #(
  parameter int NUM_STAGES      = 2,
  parameter int ADDR_W          = 18,
  parameter int DATA_W          = 16,
  parameter int TIMER_W         = 26,
  parameter int TIMEOUT_CYCLES  = 50000000,
  parameter int WATCHDOG_CYCLES = (1 << 24)
) (
  input  logic                         CLOCK_50_I,
  input  logic                         resetn,
  input  logic                         uart_rx_i,
  input  logic [ADDR_W-1:0]            uart_addr_i,
  input  logic [DATA_W-1:0]            uart_wdata_i,
  input  logic                         uart_we_n_i,
  output logic                         uart_rx_initialize_o,
  output logic                         uart_rx_enable_o,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_addr_i,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_wdata_i,
  input  logic [NUM_STAGES-1:0]        stage_we_n_i,
  input  logic [NUM_STAGES-1:0]        stage_finish_i,
  output logic [NUM_STAGES-1:0]        stage_start_o,
  input  logic [ADDR_W-1:0]            vga_addr_i,
  output logic                         vga_enable_o,
  output logic [ADDR_W-1:0]            sram_address_o,
  output logic [DATA_W-1:0]            sram_write_data_o,
  output logic                         sram_we_n_o,
  output logic [2:0]                   stage_idx_o,
  output logic                         busy_o,
  output logic                         error_o
);

  localparam int                 IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]         LAST_IDX   = 3'(NUM_STAGES - 1);

  // Elaboration-time guard against unsupported configurations.
  if (NUM_STAGES < 1 || NUM_STAGES > 8 || TIMEOUT_CYCLES < 1 || WATCHDOG_CYCLES < 2) begin : g_bad_params
    $error("sram_phase_sequencer: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_UART_RX = 2'd1,
    S_STAGE   = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t                r_state;
  logic [TIMER_W-1:0]    r_timer;
  logic [2:0]            r_stage_idx;
  logic [NUM_STAGES-1:0] r_start;
  logic                  r_init;
  logic                  r_enable;
  logic                  r_vga_en;

`ifdef STAGE_WATCHDOG_EN
  localparam int              WD_W    = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
  logic [WD_W-1:0]            r_wd;
  logic                       r_error;
`endif

  // Unpacked views of the packed stage buses, indexed by the active stage.
  logic [ADDR_W-1:0] w_stage_addr  [NUM_STAGES];
  logic [DATA_W-1:0] w_stage_wdata [NUM_STAGES];
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_unpack
    assign w_stage_addr[k]  = stage_addr_i[k*ADDR_W +: ADDR_W];
    assign w_stage_wdata[k] = stage_wdata_i[k*DATA_W +: DATA_W];
  end

  logic [IDX_W-1:0] w_idx;
  logic             w_finish_active;
  assign w_idx           = r_stage_idx[IDX_W-1:0];
  assign w_finish_active = stage_finish_i[w_idx];

  // One-hot start pattern for a stage index.
  function automatic logic [NUM_STAGES-1:0] f_onehot(input logic [2:0] idx);
    logic [NUM_STAGES-1:0] v;
    v = {NUM_STAGES{1'b0}};
    for (int k = 0; k < NUM_STAGES; k++) begin
      v[k] = (idx == 3'(k));
    end
    return v;
  endfunction

  // Phase FSM with registered handshake outputs.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_timer     <= {TIMER_W{1'b0}};
      r_stage_idx <= 3'd0;
      r_start     <= {NUM_STAGES{1'b0}};
      r_init      <= 1'b0;
      r_enable    <= 1'b0;
      r_vga_en    <= 1'b1;
`ifdef STAGE_WATCHDOG_EN
      r_wd        <= {WD_W{1'b0}};
      r_error     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_enable <= 1'b0;
          if (!uart_rx_i) begin
            r_init   <= 1'b1;
            r_timer  <= {TIMER_W{1'b0}};
            r_vga_en <= 1'b0;
            r_state  <= S_UART_RX;
          end else begin
            r_init   <= 1'b0;
            r_vga_en <= 1'b1;
          end
        end
        S_UART_RX: begin
          r_init   <= 1'b0;
          r_enable <= r_init;
          // A write restarts the idle count, even on the would-be timeout cycle.
          if (!uart_we_n_i) begin
            r_timer <= {TIMER_W{1'b0}};
          end else if (r_timer == TIMER_LAST) begin
            r_timer     <= {TIMER_W{1'b0}};
            r_stage_idx <= 3'd0;
            r_start     <= f_onehot(3'd0);
`ifdef STAGE_WATCHDOG_EN
            r_wd        <= {WD_W{1'b0}};
`endif
            r_state     <= S_STAGE;
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end
        S_STAGE: begin
          if (w_finish_active) begin
            r_start <= {NUM_STAGES{1'b0}};
            r_state <= S_GAP;
          end
`ifdef STAGE_WATCHDOG_EN
          else if (r_wd == WD_LAST) begin
            r_start     <= {NUM_STAGES{1'b0}};
            r_error     <= 1'b1;
            r_stage_idx <= 3'd0;
            r_vga_en    <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_wd    <= r_wd + WD_W'(1);
            r_start <= f_onehot(r_stage_idx);
          end
`else
          else begin
            r_start <= f_onehot(r_stage_idx);
          end
`endif
        end
        S_GAP: begin
          if (r_stage_idx == LAST_IDX) begin
            r_stage_idx <= 3'd0;
            r_vga_en    <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_stage_idx <= r_stage_idx + 3'd1;
            r_start     <= f_onehot(r_stage_idx + 3'd1);
`ifdef STAGE_WATCHDOG_EN
            r_wd        <= {WD_W{1'b0}};
`endif
            r_state     <= S_STAGE;
          end
        end
        default: begin
          r_start     <= {NUM_STAGES{1'b0}};
          r_stage_idx <= 3'd0;
          r_init      <= 1'b0;
          r_enable    <= 1'b0;
          r_vga_en    <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  logic [ADDR_W-1:0] w_sram_addr;
  logic [DATA_W-1:0] w_sram_wdata;
  logic              w_sram_we_n;

  // SRAM owner mux, decoded from the registered state only.
  always_comb begin
    w_sram_addr  = vga_addr_i;
    w_sram_wdata = {DATA_W{1'b0}};
    w_sram_we_n  = 1'b1;
    case (r_state)
      S_UART_RX: begin
        w_sram_addr  = uart_addr_i;
        w_sram_wdata = uart_wdata_i;
        w_sram_we_n  = uart_we_n_i;
      end
      S_STAGE: begin
        w_sram_addr  = w_stage_addr[w_idx];
        w_sram_wdata = w_stage_wdata[w_idx];
        w_sram_we_n  = stage_we_n_i[w_idx];
      end
      S_GAP: begin
        // Keep the finished stage's address but block any write.
        w_sram_addr  = w_stage_addr[w_idx];
        w_sram_wdata = {DATA_W{1'b0}};
        w_sram_we_n  = 1'b1;
      end
      default: begin
        w_sram_addr  = vga_addr_i;
        w_sram_wdata = {DATA_W{1'b0}};
        w_sram_we_n  = 1'b1;
      end
    endcase
  end

  assign sram_address_o       = w_sram_addr;
  assign sram_write_data_o    = w_sram_wdata;
  assign sram_we_n_o          = w_sram_we_n;
  assign stage_start_o        = r_start;
  assign uart_rx_initialize_o = r_init;
  assign uart_rx_enable_o     = r_enable;
  assign vga_enable_o         = r_vga_en;
  assign stage_idx_o          = r_stage_idx;
  assign busy_o               = (r_state != S_IDLE);
`ifdef STAGE_WATCHDOG_EN
  assign error_o              = r_error;
`else
  assign error_o              = 1'b0;
`endif

endmodule

// File: tb/tb_sram_phase_sequencer.sv
// Directed testbench for sram_phase_sequencer (TIMEOUT_CYCLES=100, NUM_STAGES=2).
module tb_sram_phase_sequencer;

  localparam int NS = 2;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int TW = 26;
  localparam int TO = 100;
  localparam int WD = 64;

  localparam logic [AW-1:0] A_VGA   = 18'h1234A;
  localparam logic [AW-1:0] A_UART  = 18'h00111;
  localparam logic [AW-1:0] A_UART2 = 18'h3F00F;
  localparam logic [AW-1:0] A_S0    = 18'h1AAAA;
  localparam logic [AW-1:0] A_S1    = 18'h2BBBB;
  localparam logic [DW-1:0] D_UART  = 16'hAAAA;
  localparam logic [DW-1:0] D_S0    = 16'h5050;
  localparam logic [DW-1:0] D_S1    = 16'h5151;

  logic             CLOCK_50_I = 1'b0;
  logic             resetn;
  logic             uart_rx_i;
  logic [AW-1:0]    uart_addr_i;
  logic [DW-1:0]    uart_wdata_i;
  logic             uart_we_n_i;
  logic             uart_rx_initialize_o;
  logic             uart_rx_enable_o;
  logic [NS*AW-1:0] stage_addr_i;
  logic [NS*DW-1:0] stage_wdata_i;
  logic [NS-1:0]    stage_we_n_i;
  logic [NS-1:0]    stage_finish_i;
  logic [NS-1:0]    stage_start_o;
  logic [AW-1:0]    vga_addr_i;
  logic             vga_enable_o;
  logic [AW-1:0]    sram_address_o;
  logic [DW-1:0]    sram_write_data_o;
  logic             sram_we_n_o;
  logic [2:0]       stage_idx_o;
  logic             busy_o;
  logic             error_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLOCK_50_I = ~CLOCK_50_I;

  sram_phase_sequencer #(
    .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMER_W(TW),
    .TIMEOUT_CYCLES(TO), .WATCHDOG_CYCLES(WD)
  ) dut (
    .CLOCK_50_I(CLOCK_50_I), .resetn(resetn),
    .uart_rx_i(uart_rx_i), .uart_addr_i(uart_addr_i), .uart_wdata_i(uart_wdata_i),
    .uart_we_n_i(uart_we_n_i), .uart_rx_initialize_o(uart_rx_initialize_o),
    .uart_rx_enable_o(uart_rx_enable_o), .stage_addr_i(stage_addr_i),
    .stage_wdata_i(stage_wdata_i), .stage_we_n_i(stage_we_n_i),
    .stage_finish_i(stage_finish_i), .stage_start_o(stage_start_o),
    .vga_addr_i(vga_addr_i), .vga_enable_o(vga_enable_o),
    .sram_address_o(sram_address_o), .sram_write_data_o(sram_write_data_o),
    .sram_we_n_o(sram_we_n_o), .stage_idx_o(stage_idx_o),
    .busy_o(busy_o), .error_o(error_o)
  );

  task automatic tick();
    @(posedge CLOCK_50_I);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},  32'(busy_o), 32'd0);
    chk({tag, "_vga"},   32'(vga_enable_o), 32'd1);
    chk({tag, "_start"}, 32'(stage_start_o), 32'd0);
    chk({tag, "_init"},  32'(uart_rx_initialize_o), 32'd0);
    chk({tag, "_en"},    32'(uart_rx_enable_o), 32'd0);
    chk({tag, "_idx"},   32'(stage_idx_o), 32'd0);
    chk({tag, "_err"},   32'(error_o), 32'd0);
    chk({tag, "_addr"},  32'(sram_address_o), 32'(A_VGA));
    chk({tag, "_wdata"}, 32'(sram_write_data_o), 32'd0);
    chk({tag, "_we_n"},  32'(sram_we_n_o), 32'd1);
  endtask

  // Start a reception with no writes; returns one settle step after S_STAGE entry.
  task automatic enter_stage_no_writes(input string tag);
    uart_rx_i = 1'b0;
    tick();
    uart_rx_i = 1'b1;
    #1;
    chk({tag, "_init"}, 32'(uart_rx_initialize_o), 32'd1);
    for (int i = 0; i < TO - 1; i++) begin
      tick();
    end
    chk({tag, "_start_before_timeout"}, 32'(stage_start_o), 32'd0);
    tick();
    chk({tag, "_start_at_timeout"}, 32'(stage_start_o), 32'd1);
    chk({tag, "_addr_s0"}, 32'(sram_address_o), 32'(A_S0));
  endtask

  initial begin
    resetn         = 1'b0;
    uart_rx_i      = 1'b1;
    uart_addr_i    = A_UART;
    uart_wdata_i   = D_UART;
    uart_we_n_i    = 1'b1;
    stage_addr_i   = {A_S1, A_S0};
    stage_wdata_i  = {D_S1, D_S0};
    stage_we_n_i   = 2'b11;
    stage_finish_i = 2'b00;
    vga_addr_i     = A_VGA;

    repeat (3) tick();
    chk_reset("rst");
    resetn = 1'b1;
    tick();
    chk_reset("idle");

    // Run 1: start bit, initialize/enable pulses.
    uart_rx_i = 1'b0;
    #1;
    chk("idle_before_edge_busy", 32'(busy_o), 32'd0);
    tick();                                   // E1: S_UART_RX
    uart_rx_i = 1'b1;
    #1;
    chk("rx_init_hi", 32'(uart_rx_initialize_o), 32'd1);
    chk("rx_en_lo", 32'(uart_rx_enable_o), 32'd0);
    chk("rx_vga_lo", 32'(vga_enable_o), 32'd0);
    chk("rx_busy", 32'(busy_o), 32'd1);
    chk("rx_addr", 32'(sram_address_o), 32'(A_UART));
    chk("rx_wdata", 32'(sram_write_data_o), 32'(D_UART));
    chk("rx_we_n", 32'(sram_we_n_o), 32'd1);
    chk("rx_idx", 32'(stage_idx_o), 32'd0);
    tick();                                   // E2
    chk("rx_init_lo", 32'(uart_rx_initialize_o), 32'd0);
    chk("rx_en_hi", 32'(uart_rx_enable_o), 32'd1);
    tick();                                   // E3
    chk("rx_en_one_cycle", 32'(uart_rx_enable_o), 32'd0);
    uart_rx_i = 1'b0;
    tick();                                   // E4: line low ignored here
    uart_rx_i = 1'b1;
    #1;
    chk("rx_line_ignored_init", 32'(uart_rx_initialize_o), 32'd0);
    chk("rx_line_ignored_busy", 32'(busy_o), 32'd1);
    repeat (47) tick();                       // E51: timer == 50
    uart_we_n_i = 1'b0;
    uart_addr_i = A_UART2;
    #1;
    chk("rx_write_we_n", 32'(sram_we_n_o), 32'd0);
    chk("rx_write_addr", 32'(sram_address_o), 32'(A_UART2));
    tick();                                   // E52: timer clears
    uart_we_n_i = 1'b1;
    #1;
    chk("rx_after_write_we_n", 32'(sram_we_n_o), 32'd1);
    for (int i = 0; i < TO - 1; i++) begin   // E53..E151
      tick();
      chk("rx_no_early_start", 32'(stage_start_o), 32'd0);
    end

    // Stage 0 with stage 1 finish held high (must be ignored).
    stage_finish_i = 2'b10;
    stage_we_n_i   = 2'b10;
    tick();                                   // E152: S_STAGE, idx 0
    chk("s0_start", 32'(stage_start_o), 32'h1);
    chk("s0_idx", 32'(stage_idx_o), 32'd0);
    chk("s0_addr", 32'(sram_address_o), 32'(A_S0));
    chk("s0_wdata", 32'(sram_write_data_o), 32'(D_S0));
    chk("s0_we_n", 32'(sram_we_n_o), 32'd0);
    chk("s0_vga", 32'(vga_enable_o), 32'd0);
    for (int i = 0; i < 19; i++) begin        // E153..E171
      tick();
      chk("s0_start_held", 32'(stage_start_o), 32'h1);
    end
    stage_finish_i = 2'b11;
    tick();                                   // E172: S_GAP
    chk("gap0_start", 32'(stage_start_o), 32'h0);
    chk("gap0_we_n", 32'(sram_we_n_o), 32'd1);
    chk("gap0_wdata", 32'(sram_write_data_o), 32'd0);
    chk("gap0_addr", 32'(sram_address_o), 32'(A_S0));
    chk("gap0_idx", 32'(stage_idx_o), 32'd0);
    chk("gap0_busy", 32'(busy_o), 32'd1);
    stage_we_n_i = 2'b00;
    tick();                                   // E173: S_STAGE, idx 1
    chk("s1_start", 32'(stage_start_o), 32'h2);
    chk("s1_idx", 32'(stage_idx_o), 32'd1);
    chk("s1_addr", 32'(sram_address_o), 32'(A_S1));
    chk("s1_wdata", 32'(sram_write_data_o), 32'(D_S1));
    chk("s1_we_n", 32'(sram_we_n_o), 32'd0);
    tick();                                   // E174: finish held -> S_GAP
    chk("gap1_start", 32'(stage_start_o), 32'h0);
    chk("gap1_addr", 32'(sram_address_o), 32'(A_S1));
    chk("gap1_we_n", 32'(sram_we_n_o), 32'd1);
    chk("gap1_idx", 32'(stage_idx_o), 32'd1);
    stage_finish_i = 2'b00;
    stage_we_n_i   = 2'b11;
    tick();                                   // E175: S_IDLE
    chk_reset("done");

    // Run 2: timeout from entry with no writes, then reset mid-stage.
    enter_stage_no_writes("run2");
    repeat (10) tick();
    chk("run2_start_mid", 32'(stage_start_o), 32'h1);
    resetn = 1'b0;
    #1;
    chk_reset("async_rst");
    tick();
    resetn = 1'b1;
    tick();
    chk_reset("post_rst");

    // Run 3: a stage that never finishes.
    enter_stage_no_writes("run3");
`ifdef STAGE_WATCHDOG_EN
    for (int i = 0; i < WD - 1; i++) begin
      tick();
      chk("wd_start_held", 32'(stage_start_o), 32'h1);
    end
    tick();
    chk("wd_start_drop", 32'(stage_start_o), 32'h0);
    chk("wd_error", 32'(error_o), 32'd1);
    chk("wd_busy", 32'(busy_o), 32'd0);
    chk("wd_vga", 32'(vga_enable_o), 32'd1);
    chk("wd_addr", 32'(sram_address_o), 32'(A_VGA));
    tick();
    chk("wd_error_sticky", 32'(error_o), 32'd1);
`else
    repeat (WD + 6) tick();
    chk("nowd_start_held", 32'(stage_start_o), 32'h1);
    chk("nowd_error", 32'(error_o), 32'd0);
    chk("nowd_busy", 32'(busy_o), 32'd1);
`endif
    resetn = 1'b0;
    #1;
    chk_reset("final_rst");
    tick();
    resetn = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
